// File: rtl/peripheral_pkg.sv
// Shared constants and types for the memory-mapped peripheral block.
package peripheral_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LED_W  = 8;
   localparam int unsigned SW_W   = 8;
   localparam int unsigned DIGI_W = 12;
   localparam int unsigned PRE_W  = 16;
   localparam int unsigned OFF_W  = 5;
   localparam int unsigned TCON_W = 3;

   localparam logic [OFF_W-1:0] TH_OFF     = 5'h00;
   localparam logic [OFF_W-1:0] TL_OFF     = 5'h04;
   localparam logic [OFF_W-1:0] TCON_OFF   = 5'h08;
   localparam logic [OFF_W-1:0] LED_OFF    = 5'h0C;
   localparam logic [OFF_W-1:0] SWITCH_OFF = 5'h10;
   localparam logic [OFF_W-1:0] DIGI_OFF   = 5'h14;

   localparam int unsigned TCON_EN = 0;
   localparam int unsigned TCON_IE = 1;
   localparam int unsigned TCON_IS = 2;

   // Decoded write strobes handed from the bus decoder to the timer.
   typedef struct packed {
      logic th;
      logic tl;
      logic tcon;
   } timer_we_t;

endpackage

// File: rtl/peripheral_bus_if.sv
// CPU data-side bus as seen by the peripheral block.
interface peripheral_bus_if;
   logic                              rd;
   logic                              wr;
   logic [peripheral_pkg::ADDR_W-1:0] addr;
   logic [peripheral_pkg::DATA_W-1:0] wdata;
   logic [peripheral_pkg::DATA_W-1:0] rdata;

   modport master (output rd, output wr, output addr, output wdata, input rdata);
   modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/peripheral_timer.sv
// Reloadable 32-bit timer with prescaler, TCON control/status and interrupt.
module peripheral_timer
   import peripheral_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  timer_we_t         we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] th,
   output logic [DATA_W-1:0] tl,
   output logic [TCON_W-1:0] tcon,
   output logic              irqout
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [DATA_W-1:0] th_q, th_d;
   logic [DATA_W-1:0] tl_q, tl_d;
   logic [TCON_W-1:0] tcon_q, tcon_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic              tick, ovf, is_set;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
         pre_q  <= '0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
         pre_q  <= pre_d;
      end
   end

   // CPU writes take priority over counting; overflow reloads from the pre-edge TH.
   always_comb begin
      pre_d  = '0;
      tick   = tcon_q[TCON_EN] && (pre_q == PRE_LAST);
      ovf    = tick && (tl_q == '1);
      is_set = ovf && tcon_q[TCON_IE];
      th_d   = th_q;
      tl_d   = tl_q;
      tcon_d = tcon_q;

      if (tcon_q[TCON_EN] && !tick) pre_d = pre_q + PRE_W'(1);

      if (tick) tl_d = ovf ? th_q : tl_q + DATA_W'(1);
      if (we.tl) tl_d = wdata;
      if (we.th) th_d = wdata;

      // A pending overflow status is OR-ed in so a concurrent TCON write cannot drop it.
      if (we.tcon) begin
         tcon_d[TCON_EN] = wdata[TCON_EN];
         tcon_d[TCON_IE] = wdata[TCON_IE];
         tcon_d[TCON_IS] = wdata[TCON_IS] | is_set;
      end else begin
         tcon_d[TCON_IS] = tcon_q[TCON_IS] | is_set;
      end
   end

   assign th     = th_q;
   assign tl     = tl_q;
   assign tcon   = tcon_q;
   assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/peripheral_bus.sv
// Peripheral window: address decode, read mux, LED/DIGI registers, switch sync and timer.
module peripheral_bus
   import peripheral_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
   parameter int unsigned       TICK_DIV  = 1
) (
   input  logic              clk,
   input  logic              reset,
   peripheral_bus_if.slave   bus,
   input  logic [SW_W-1:0]   switch,
   output logic [LED_W-1:0]  led,
   output logic [DIGI_W-1:0] digi,
   output logic              irqout
);

   logic [ADDR_W-1:0] off;
   logic [OFF_W-1:0]  woff;
   logic              hit, wr_hit;
   timer_we_t         t_we;

   logic [LED_W-1:0]  led_q, led_d;
   logic [DIGI_W-1:0] digi_q, digi_d;
   logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

   logic [DATA_W-1:0] t_th, t_tl;
   logic [TCON_W-1:0] t_tcon;
   logic [DATA_W-1:0] rdata_c;

   // Byte offsets below the base wrap to large values and therefore miss.
   assign off    = bus.addr - BASE_ADDR;
   assign woff   = off[OFF_W-1:0] & 5'b11100;
   assign hit    = (off[ADDR_W-1:OFF_W] == '0) && (woff <= DIGI_OFF);
   assign wr_hit = bus.wr && hit;

   assign t_we.th   = wr_hit && (woff == TH_OFF);
   assign t_we.tl   = wr_hit && (woff == TL_OFF);
   assign t_we.tcon = wr_hit && (woff == TCON_OFF);

   peripheral_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .we     (t_we),
      .wdata  (bus.wdata),
      .th     (t_th),
      .tl     (t_tl),
      .tcon   (t_tcon),
      .irqout (irqout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q     <= '0;
         digi_q    <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         led_q     <= led_d;
         digi_q    <= digi_d;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
      end
   end

   always_comb begin
      led_d  = led_q;
      digi_d = digi_q;
      if (wr_hit && (woff == LED_OFF))  led_d  = bus.wdata[LED_W-1:0];
      if (wr_hit && (woff == DIGI_OFF)) digi_d = bus.wdata[DIGI_W-1:0];
   end

   always_comb begin
      rdata_c = '0;
      if (bus.rd && hit) begin
         case (woff)
            TH_OFF:     rdata_c = t_th;
            TL_OFF:     rdata_c = t_tl;
            TCON_OFF:   rdata_c = DATA_W'(t_tcon);
            LED_OFF:    rdata_c = DATA_W'(led_q);
            SWITCH_OFF: rdata_c = DATA_W'(sw_sync_q);
            DIGI_OFF:   rdata_c = DATA_W'(digi_q);
            default:    rdata_c = '0;
         endcase
      end
   end

   assign bus.rdata = rdata_c;
   assign led       = led_q;
   assign digi      = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
// Scoreboard bench for peripheral_bus: one instance with TICK_DIV=1, one with TICK_DIV=4.
module tb_peripheral_bus;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LED  = 32'h4000_000C;
   localparam logic [31:0] A_SW   = 32'h4000_0010;
   localparam logic [31:0] A_DIGI = 32'h4000_0014;

   localparam int K_RD1 = 0, K_RD4 = 1, K_LED1 = 2, K_DIGI1 = 3;
   localparam int K_IRQ1 = 4, K_IRQ4 = 5, K_LED4 = 6, K_DIGI4 = 7;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } sb_entry_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  switch = 8'h00;
   logic [7:0]  led1, led4;
   logic [11:0] digi1, digi4;
   logic        irq1, irq4;

   sb_entry_t sb[$];
   int        n_chk = 0;
   int        n_compared = 0;
   int        n_bad = 0;

   peripheral_bus_if bus1 ();
   peripheral_bus_if bus4 ();

   peripheral_bus #(.BASE_ADDR(32'h4000_0000), .TICK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave), .switch(switch),
      .led(led1), .digi(digi1), .irqout(irq1));

   peripheral_bus #(.BASE_ADDR(32'h4000_0000), .TICK_DIV(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave), .switch(switch),
      .led(led4), .digi(digi4), .irqout(irq4));

   always #5 clk = ~clk;

   // Monitor: on each falling edge, pop and compare the checks issued for this cycle.
   always @(negedge clk) begin
      for (int i = 0; i < n_chk; i++) begin
         sb_entry_t   e;
         logic [31:0] act;
         n_compared++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: check issued with no expected value queued");
         end else begin
            e = sb.pop_front();
            case (e.kind)
               K_RD1:   act = bus1.rdata;
               K_RD4:   act = bus4.rdata;
               K_LED1:  act = 32'(led1);
               K_DIGI1: act = 32'(digi1);
               K_IRQ1:  act = 32'(irq1);
               K_IRQ4:  act = 32'(irq4);
               K_LED4:  act = 32'(led4);
               default: act = 32'(digi4);
            endcase
            if (act !== e.exp) begin
               n_bad++;
               $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", e.name, act, e.exp, $time);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      bus1.rd = 1'b0; bus1.wr = 1'b0;
      bus4.rd = 1'b0; bus4.wr = 1'b0;
      n_chk = 0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic push(input int kind, input logic [31:0] exp, input string name);
      sb_entry_t e;
      e.kind = kind; e.exp = exp; e.name = name;
      sb.push_back(e);
      n_chk++;
   endtask

   task automatic wr_req(input bit d4, input logic [31:0] a, input logic [31:0] d);
      if (d4) begin bus4.wr = 1'b1; bus4.addr = a; bus4.wdata = d; end
      else    begin bus1.wr = 1'b1; bus1.addr = a; bus1.wdata = d; end
   endtask

   task automatic rd_req(input bit d4, input logic [31:0] a, input logic [31:0] exp,
                         input string name);
      if (d4) begin bus4.rd = 1'b1; bus4.addr = a; push(K_RD4, exp, name); end
      else    begin bus1.rd = 1'b1; bus1.addr = a; push(K_RD1, exp, name); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus1.rd = 0; bus1.wr = 0; bus1.addr = 0; bus1.wdata = 0;
      bus4.rd = 0; bus4.wr = 0; bus4.addr = 0; bus4.wdata = 0;
      @(posedge clk);
      #1;
      // Power-on reset state
      rd_req(0, A_TL, 32'h0, "rst_tl1");
      rd_req(1, A_TCON, 32'h0, "rst_tcon4");
      push(K_LED1, 32'h0, "rst_led1");
      push(K_DIGI1, 32'h0, "rst_digi1");
      push(K_IRQ1, 32'h0, "rst_irq1");
      push(K_LED4, 32'h0, "rst_led4");
      push(K_DIGI4, 32'h0, "rst_digi4");
      cycle();
      reset = 1'b1;
      cycle();

      // LED, DIGI, switch synchroniser
      wr_req(0, A_LED, 32'h0000_00A5); cycle();
      push(K_LED1, 32'hA5, "led_pin"); rd_req(0, A_LED, 32'hA5, "led_read"); cycle();
      wr_req(0, A_DIGI, 32'h000F_FF3A); cycle();
      push(K_DIGI1, 32'hF3A, "digi_pin"); rd_req(0, A_DIGI, 32'hF3A, "digi_read"); cycle();
      switch = 8'h3C;
      rd_req(0, A_SW, 32'h0, "sw_cyc1"); cycle();
      rd_req(0, A_SW, 32'h0, "sw_cyc2"); cycle();
      rd_req(0, A_SW, 32'h3C, "sw_cyc3"); cycle();

      // Reload and interrupt, TICK_DIV=1
      wr_req(0, A_TH, 32'hFFFF_FFFC); cycle();
      wr_req(0, A_TL, 32'hFFFF_FFFE); cycle();
      wr_req(0, A_TCON, 32'h3); cycle();
      rd_req(0, A_TL, 32'hFFFF_FFFE, "tl_enable_edge"); cycle();
      rd_req(0, A_TL, 32'hFFFF_FFFF, "tl_one_tick"); push(K_IRQ1, 32'h0, "irq_pre_ovf"); cycle();
      rd_req(0, A_TL, 32'hFFFF_FFFC, "tl_reload"); push(K_IRQ1, 32'h1, "irq_rise"); cycle();
      rd_req(0, A_TCON, 32'h7, "tcon_status"); push(K_IRQ1, 32'h1, "irq_held"); cycle();
      wr_req(0, A_TCON, 32'h3); cycle();
      push(K_IRQ1, 32'h0, "irq_cleared"); rd_req(0, A_TCON, 32'h3, "tcon_cleared"); cycle();
      wr_req(0, A_TCON, 32'h0); cycle();
      rd_req(0, A_TL, 32'hFFFF_FFFD, "tl_stop"); cycle();
      rd_req(0, A_TL, 32'hFFFF_FFFD, "tl_frozen"); cycle();

      // Collision: TCON write with bit2=0 on the overflow edge
      wr_req(0, A_TH, 32'h0); cycle();
      wr_req(0, A_TL, 32'hFFFF_FFFE); cycle();
      wr_req(0, A_TCON, 32'h3); cycle();
      cycle();
      wr_req(0, A_TCON, 32'h3); cycle();
      rd_req(0, A_TCON, 32'h7, "coll_tcon"); push(K_IRQ1, 32'h1, "coll_irq"); cycle();
      // Collision: TL write on an increment edge
      wr_req(0, A_TL, 32'h10); cycle();
      rd_req(0, A_TL, 32'h10, "coll_tl_write"); cycle();
      rd_req(0, A_TL, 32'h11, "coll_tl_next"); cycle();
      // Collision: TH write on the overflow edge reloads the old TH
      wr_req(0, A_TH, 32'h100); cycle();
      wr_req(0, A_TL, 32'hFFFF_FFFF); cycle();
      wr_req(0, A_TH, 32'h200); cycle();
      rd_req(0, A_TL, 32'h100, "coll_th_old_reload"); cycle();
      rd_req(0, A_TH, 32'h200, "coll_th_new"); cycle();
      wr_req(0, A_TCON, 32'h0); cycle();
      push(K_IRQ1, 32'h0, "irq_off"); rd_req(0, A_TCON, 32'h0, "tcon_off"); cycle();

      // Prescaler, TICK_DIV=4
      wr_req(1, A_TL, 32'h0); cycle();
      wr_req(1, A_TCON, 32'h1); cycle();
      cycles(3);
      rd_req(1, A_TL, 32'h0, "pre_before_tick"); cycle();
      rd_req(1, A_TL, 32'h1, "pre_first_tick"); cycle();
      cycles(15);
      rd_req(1, A_TL, 32'h5, "pre_20_cycles"); push(K_IRQ4, 32'h0, "pre_irq4"); cycle();
      wr_req(1, A_TCON, 32'h0); cycle();
      cycles(8);
      rd_req(1, A_TL, 32'h5, "pre_hold"); cycle();

      // Decode: unmapped and read-only writes change nothing
      wr_req(0, 32'h4000_0018, 32'hFFFF_FFFF); cycle();
      wr_req(0, A_SW, 32'hFFFF_FFFF); cycle();
      push(K_LED1, 32'hA5, "dec_led"); rd_req(0, A_TH, 32'h200, "dec_th"); cycle();
      push(K_DIGI1, 32'hF3A, "dec_digi"); rd_req(0, A_TCON, 32'h0, "dec_tcon"); cycle();
      rd_req(0, A_SW, 32'h3C, "dec_switch"); cycle();
      bus1.addr = A_LED; push(K_RD1, 32'h0, "rd_low_zero"); cycle();
      rd_req(0, 32'h4000_0018, 32'h0, "rd_unmapped"); cycle();
      rd_req(0, 32'h3FFF_FFFC, 32'h0, "rd_below_base"); cycle();
      wr_req(0, A_TCON, 32'hFFFF_FFFF); cycle();
      rd_req(0, A_TCON, 32'h7, "tcon_all_ones"); push(K_IRQ1, 32'h1, "tcon_all_irq"); cycle();
      wr_req(1, A_TCON, 32'h1); cycle();
      cycles(2);

      // Asynchronous reset mid-run, checked before any clock edge
      reset = 1'b0;
      rd_req(0, A_TL, 32'h0, "async_tl1");
      rd_req(1, A_TL, 32'h0, "async_tl4");
      push(K_LED1, 32'h0, "async_led");
      push(K_DIGI1, 32'h0, "async_digi");
      push(K_IRQ1, 32'h0, "async_irq");
      cycle();
      rd_req(0, A_TCON, 32'h0, "async_tcon1");
      rd_req(1, A_TCON, 32'h0, "async_tcon4");
      cycle();
      reset = 1'b1;
      cycle();
      rd_req(0, A_TL, 32'h0, "post_rst_tl"); rd_req(1, A_TH, 32'h0, "post_rst_th4"); cycle();

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_bad += sb.size();
         $display("FAIL scoreboard_leftover: %0d expected values never compared (want 0)", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_bad);
      $finish;
   end

endmodule
